player_move: RTL and testbench

Player movement controller for the maze game. It consumes the one-cycle direction strobes from the keyboard stage, checks the target cell against the current level's wall bitmap, and updates the player position. It emits update, bump and level-up pulses to the renderer and level sequencer. It sits between the key stage and the top-level map/level logic.

---
 rtl/player_move.sv | 162 ++++++++++++++++
 tb/tb_player_move.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/player_move.sv
// Player movement controller: validates one-hot direction strobes against the wall map, then moves the player.
// Latency: key sampled at E0, new position and update/bump pulse at E1, level-up pulse at E2.
// Backpressure: none; keys arriving in CHECK, MOVE or GOAL are dropped, and a load discards any in-flight move.
module player_move #(
  parameter int ROW    = 15,
  parameter int COLUME = 20
) (
  input  logic                    i_Clk,
  input  logic                    i_Rst,
  input  logic [3:0]              i_Direction,
  input  logic                    i_fKey,
  input  logic                    i_fRunning,
  input  logic                    i_fLoad,
  input  logic [ROW*COLUME-1:0]   i_Map,
  input  logic [6:0]              i_StartX,
  input  logic [5:0]              i_StartY,
  input  logic [6:0]              i_GoalX,
  input  logic [5:0]              i_GoalY,
  output logic [6:0]              o_PosX,
  output logic [5:0]              o_PosY,
  output logic                    o_fUpdate,
  output logic                    o_fBump,
  output logic                    o_fLevelUp,
  output logic [9:0]              o_MoveCount
);

  typedef enum logic [1:0] {IDLE, CHECK, MOVE, GOAL} state_t;

  state_t state, state_nxt;

  logic [6:0]  pos_x, pos_x_nxt, tgt_x, tgt_x_nxt;
  logic [5:0]  pos_y, pos_y_nxt, tgt_y, tgt_y_nxt;
  logic        edge_q, edge_nxt;
  logic [9:0]  move_count, move_count_nxt;
  logic        update_nxt, bump_nxt, levelup_nxt;
  logic        update_q, bump_q, levelup_q;

  logic        dir_onehot;
  logic        key_ok;
  logic        dir_edge;
  logic [12:0] map_idx;
  logic [ROW*COLUME-1:0] map_shift;
  logic        wall;

  // A direction is valid only when exactly one bit is set.
  assign dir_onehot = (i_Direction != 4'd0) && ((i_Direction & (i_Direction - 4'd1)) == 4'd0);
  assign key_ok     = i_fKey && i_fRunning && dir_onehot;

  // Moving off the maze border is a bump; this also keeps the map index in range.
  assign dir_edge = (i_Direction[0] && (pos_y == 6'd0))              ||
                    (i_Direction[1] && (pos_y == 6'(ROW - 1)))       ||
                    (i_Direction[2] && (pos_x == 7'd0))              ||
                    (i_Direction[3] && (pos_x == 7'(COLUME - 1)));

  // Shift instead of a variable bit-select so the 13-bit index needs no resizing.
  assign map_idx   = 13'(tgt_y) * 13'(COLUME) + 13'(tgt_x);
  assign map_shift = i_Map >> map_idx;
  assign wall      = map_shift[0];

  // State register: reset beats load, load beats the FSM.
  always_ff @(posedge i_Clk) begin
    if (i_Rst)        state <= IDLE;
    else if (i_fLoad) state <= IDLE;
    else              state <= state_nxt;
  end

  // Next-state, datapath and pulse decisions.
  always_comb begin
    state_nxt      = state;
    tgt_x_nxt      = tgt_x;
    tgt_y_nxt      = tgt_y;
    edge_nxt       = edge_q;
    pos_x_nxt      = pos_x;
    pos_y_nxt      = pos_y;
    move_count_nxt = move_count;
    update_nxt     = 1'b0;
    bump_nxt       = 1'b0;
    levelup_nxt    = 1'b0;
    case (state)
      IDLE: begin
        if (key_ok) begin
          // On an edge the target stays on the current cell rather than wrapping.
          tgt_x_nxt = pos_x;
          tgt_y_nxt = pos_y;
          if (!dir_edge) begin
            if (i_Direction[0]) tgt_y_nxt = pos_y - 6'd1;
            if (i_Direction[1]) tgt_y_nxt = pos_y + 6'd1;
            if (i_Direction[2]) tgt_x_nxt = pos_x - 7'd1;
            if (i_Direction[3]) tgt_x_nxt = pos_x + 7'd1;
          end
          edge_nxt  = dir_edge;
          state_nxt = CHECK;
        end
      end
      CHECK: begin
        if (edge_q || wall) begin
          bump_nxt  = 1'b1;
          state_nxt = IDLE;
        end else begin
          pos_x_nxt  = tgt_x;
          pos_y_nxt  = tgt_y;
          update_nxt = 1'b1;
          if (move_count != 10'd1023) move_count_nxt = move_count + 10'd1;
          state_nxt  = MOVE;
        end
      end
      MOVE: begin
        if ((pos_x == i_GoalX) && (pos_y == i_GoalY)) begin
          levelup_nxt = 1'b1;
          state_nxt   = GOAL;
        end else begin
          state_nxt = IDLE;
        end
      end
      GOAL: state_nxt = GOAL;
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath registers; a load restarts the level and suppresses any pulse.
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      pos_x      <= 7'd0;
      pos_y      <= 6'd0;
      tgt_x      <= 7'd0;
      tgt_y      <= 6'd0;
      edge_q     <= 1'b0;
      move_count <= 10'd0;
      update_q   <= 1'b0;
      bump_q     <= 1'b0;
      levelup_q  <= 1'b0;
    end else if (i_fLoad) begin
      pos_x      <= i_StartX;
      pos_y      <= i_StartY;
      tgt_x      <= i_StartX;
      tgt_y      <= i_StartY;
      edge_q     <= 1'b0;
      move_count <= 10'd0;
      update_q   <= 1'b0;
      bump_q     <= 1'b0;
      levelup_q  <= 1'b0;
    end else begin
      pos_x      <= pos_x_nxt;
      pos_y      <= pos_y_nxt;
      tgt_x      <= tgt_x_nxt;
      tgt_y      <= tgt_y_nxt;
      edge_q     <= edge_nxt;
      move_count <= move_count_nxt;
      update_q   <= update_nxt;
      bump_q     <= bump_nxt;
      levelup_q  <= levelup_nxt;
    end
  end

  assign o_PosX      = pos_x;
  assign o_PosY      = pos_y;
  assign o_MoveCount = move_count;
  assign o_fUpdate   = update_q;
  assign o_fBump     = bump_q;
  assign o_fLevelUp  = levelup_q;

endmodule

// File: tb/tb_player_move.sv
// Directed bench for player_move: hand-computed positions, counts and pulses.
// Inputs change 1 time unit after the rising edge; outputs are checked there too.
// A negedge monitor counts cycles with more than one pulse high.
module tb_player_move;

  localparam int ROW    = 15;
  localparam int COLUME = 20;

  logic                  i_Clk = 1'b0;
  logic                  i_Rst;
  logic [3:0]            i_Direction;
  logic                  i_fKey;
  logic                  i_fRunning;
  logic                  i_fLoad;
  logic [ROW*COLUME-1:0] i_Map;
  logic [6:0]            i_StartX;
  logic [5:0]            i_StartY;
  logic [6:0]            i_GoalX;
  logic [5:0]            i_GoalY;
  logic [6:0]            o_PosX;
  logic [5:0]            o_PosY;
  logic                  o_fUpdate;
  logic                  o_fBump;
  logic                  o_fLevelUp;
  logic [9:0]            o_MoveCount;

  int checks = 0;
  int errors = 0;
  int multi_pulse = 0;
  int upd_seen = 0;

  player_move #(.ROW(ROW), .COLUME(COLUME)) dut (
    .i_Clk(i_Clk), .i_Rst(i_Rst), .i_Direction(i_Direction), .i_fKey(i_fKey),
    .i_fRunning(i_fRunning), .i_fLoad(i_fLoad), .i_Map(i_Map),
    .i_StartX(i_StartX), .i_StartY(i_StartY), .i_GoalX(i_GoalX), .i_GoalY(i_GoalY),
    .o_PosX(o_PosX), .o_PosY(o_PosY), .o_fUpdate(o_fUpdate), .o_fBump(o_fBump),
    .o_fLevelUp(o_fLevelUp), .o_MoveCount(o_MoveCount)
  );

  always #5 i_Clk = ~i_Clk;

  always @(negedge i_Clk) begin
    if ((int'(o_fUpdate) + int'(o_fBump) + int'(o_fLevelUp)) > 1) multi_pulse++;
  end

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_Clk);
    #1;
  endtask

  task automatic chk_pos(input string tag, input int x, input int y, input int cnt);
    chk({tag, "_x"}, int'(o_PosX), x);
    chk({tag, "_y"}, int'(o_PosY), y);
    chk({tag, "_cnt"}, int'(o_MoveCount), cnt);
  endtask

  task automatic chk_pulse(input string tag, input int u, input int b, input int l);
    chk({tag, "_upd"}, int'(o_fUpdate), u);
    chk({tag, "_bump"}, int'(o_fBump), b);
    chk({tag, "_lvl"}, int'(o_fLevelUp), l);
  endtask

  task automatic key(input logic [3:0] d);
    i_Direction = d;
    i_fKey      = 1'b1;
    tick();
    i_fKey      = 1'b0;
    i_Direction = 4'd0;
  endtask

  task automatic load(input int x, input int y);
    i_StartX = 7'(x);
    i_StartY = 6'(y);
    i_fLoad  = 1'b1;
    tick();
    i_fLoad  = 1'b0;
  endtask

  initial begin
    i_Rst = 1'b1; i_Direction = 4'd0; i_fKey = 1'b0; i_fRunning = 1'b1; i_fLoad = 1'b0;
    i_Map = '0; i_StartX = 7'd0; i_StartY = 6'd0; i_GoalX = 7'd10; i_GoalY = 6'd10;
    i_Map[3*COLUME+4] = 1'b1;   // wall at (4,3)
    tick(); tick();
    chk_pos("reset", 0, 0, 0);
    chk_pulse("reset", 0, 0, 0);
    i_Rst = 1'b0;

    // Load start (3,4)
    load(3, 4);
    chk_pos("load", 3, 4, 0);
    chk_pulse("load", 0, 0, 0);

    // Move right into open (4,4)
    key(4'b1000);
    chk_pulse("right_e0", 0, 0, 0);
    chk_pos("right_e0", 3, 4, 0);
    tick();
    chk_pos("right_e1", 4, 4, 1);
    chk_pulse("right_e1", 1, 0, 0);
    tick();
    chk_pulse("right_e2", 0, 0, 0);

    // Up into the wall at (4,3)
    key(4'b0001);
    tick();
    chk_pulse("wall_e1", 0, 1, 0);
    chk_pos("wall_e1", 4, 4, 1);
    tick();
    chk_pulse("wall_e2", 0, 0, 0);

    // Map changes between key and CHECK: the new wall at (5,4) is seen
    key(4'b1000);
    i_Map[4*COLUME+5] = 1'b1;
    tick();
    chk_pulse("mapchg", 0, 1, 0);
    chk_pos("mapchg", 4, 4, 1);
    i_Map[4*COLUME+5] = 1'b0;
    tick();

    // Goal (5,4): update, then level-up, then keys ignored
    i_GoalX = 7'd5; i_GoalY = 6'd4;
    key(4'b1000);
    tick();
    chk_pulse("goal_e1", 1, 0, 0);
    chk_pos("goal_e1", 5, 4, 2);
    tick();
    chk_pulse("goal_e2", 0, 0, 1);
    tick();
    chk_pulse("goal_e3", 0, 0, 0);
    key(4'b0100);
    tick(); tick();
    chk_pos("goal_hold", 5, 4, 2);
    chk_pulse("goal_hold", 0, 0, 0);
    load(3, 4);
    chk_pos("goal_reload", 3, 4, 0);
    i_GoalX = 7'd10; i_GoalY = 6'd10;

    // Edge cases: left at (0,0), down/right at the far corner
    load(0, 0);
    key(4'b0100);
    tick();
    chk_pulse("edge_left", 0, 1, 0);
    chk_pos("edge_left", 0, 0, 0);
    tick();
    load(COLUME-1, ROW-1);
    key(4'b0010);
    tick();
    chk_pulse("edge_down", 0, 1, 0);
    chk_pos("edge_down", COLUME-1, ROW-1, 0);
    tick();
    key(4'b1000);
    tick();
    chk_pulse("edge_right", 0, 1, 0);
    tick();

    // Multi-hot direction is ignored
    load(3, 4);
    key(4'b0101);
    chk_pulse("multihot_e0", 0, 0, 0);
    tick();
    chk_pulse("multihot_e1", 0, 0, 0);
    chk_pos("multihot", 3, 4, 0);

    // Not running: ignored
    i_fRunning = 1'b0;
    key(4'b1000);
    tick();
    chk_pulse("notrun", 0, 0, 0);
    chk_pos("notrun", 3, 4, 0);
    i_fRunning = 1'b1;
    tick();

    // Load and key in the same cycle: load wins
    key(4'b1000);
    tick(); tick();
    chk_pos("preload", 4, 4, 1);
    i_StartX = 7'd3; i_StartY = 6'd4;
    i_fLoad = 1'b1; i_fKey = 1'b1; i_Direction = 4'b1000;
    tick();
    i_fLoad = 1'b0; i_fKey = 1'b0; i_Direction = 4'd0;
    chk_pos("loadkey_e0", 3, 4, 0);
    tick();
    chk_pulse("loadkey_e1", 0, 0, 0);
    chk_pos("loadkey_e1", 3, 4, 0);

    // Reset while in CHECK
    key(4'b1000);
    i_Rst = 1'b1;
    tick();
    i_Rst = 1'b0;
    chk_pos("rstchk", 0, 0, 0);
    chk_pulse("rstchk", 0, 0, 0);
    tick();
    chk_pulse("rstchk_e2", 0, 0, 0);

    // 1030 successful moves saturate the counter at 1023
    i_GoalX = 7'd100; i_GoalY = 6'd50;
    load(0, 0);
    for (int i = 0; i < 1030; i++) begin
      key((i % 2 == 0) ? 4'b1000 : 4'b0100);
      tick();
      if (o_fUpdate) upd_seen++;
      tick();
    end
    chk("sat_updates", upd_seen, 1030);
    chk_pos("sat", 0, 0, 1023);

    chk("one_pulse", multi_pulse, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
